axi4_lite_regfile_slave: RTL and testbench

- Parametrised AXI4-Lite slave that backs a bank of NUM_REGS software-visible registers of DATA_WIDTH bits.
- Successor to the empty AXI4 slave shell. Adds independent AW/W capture, byte strobes, address decode with error response, single-outstanding read/write pipelines, and full B/R back-pressure.
- Sits behind the NoC network interface as the standard target endpoint for control/status registers.

---
 rtl/axi4_pkg.sv | 29 ++
 rtl/axi4_skid_hold.sv | 43 ++++
 rtl/axi4_lite_regfile_slave.sv | 176 +++++++++++++++++
 tb/tb_axi4_lite_regfile_slave.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4-Lite definitions: response codes, word-offset helper and byte-lane merge.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported data bus; narrower buses are zero-extended into the merge helper.
    localparam int MAX_DATA_WIDTH = 64;

    function automatic int calc_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0]   old_val,
        input logic [MAX_DATA_WIDTH-1:0]   new_val,
        input logic [MAX_DATA_WIDTH/8-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_val;
        for (int b = 0; b < MAX_DATA_WIDTH / 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_skid_hold.sv
// One-entry valid/ready holding register; ready is registered and drops while an entry is held.
module axi4_skid_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_held,
    output logic [WIDTH-1:0] o_data
);

    logic             r_held;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;
    logic             w_held_next;

    assign w_accept    = i_valid && r_ready;
    assign w_held_next = w_accept || (r_held && !i_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_held  <= w_held_next;
            r_ready <= !w_held_next;
            if (w_accept) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_held  = r_held;
    assign o_data  = r_data;

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave backing NUM_REGS registers with byte strobes and SLVERR decode.
// Define AXI_SLV_ID_REG_EN to make register 0 a read-only ID register returning ID_VALUE.
module axi4_lite_regfile_slave
    import axi4_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4E4F_4301
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = calc_lsb(DATA_WIDTH);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

`ifdef AXI_SLV_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> LSB) < NUM_REGS_A;
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] shifted;
        shifted = addr >> LSB;
        return shifted[IDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0]        r_regs [NUM_REGS];

    logic                         w_aw_held;
    logic [ADDR_WIDTH-1:0]        w_aw_addr;
    logic                         w_w_held;
    logic [STRB_W+DATA_WIDTH-1:0] w_w_bundle;
    logic [DATA_WIDTH-1:0]        w_w_data;
    logic [STRB_W-1:0]            w_w_strb;

    logic                         w_commit;
    logic [IDX_W-1:0]             w_wr_idx;
    logic                         w_wr_ok;
    logic [DATA_WIDTH-1:0]        w_merged;

    logic                         r_bvalid;
    logic [1:0]                   r_bresp;

    logic                         r_arready;
    logic                         r_rvalid;
    logic [DATA_WIDTH-1:0]        r_rdata;
    logic [1:0]                   r_rresp;
    logic                         w_ar_accept;
    logic                         w_rvalid_next;
    logic                         w_rd_in_range;
    logic [IDX_W-1:0]             w_rd_idx;
    logic [DATA_WIDTH-1:0]        w_rd_value;

    axi4_skid_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk     (clk),
        .reset   (reset),
        .i_valid (awvalid),
        .o_ready (awready),
        .i_data  (awaddr),
        .i_pop   (w_commit),
        .o_held  (w_aw_held),
        .o_data  (w_aw_addr)
    );

    axi4_skid_hold #(.WIDTH(STRB_W + DATA_WIDTH)) u_w_hold (
        .clk     (clk),
        .reset   (reset),
        .i_valid (wvalid),
        .o_ready (wready),
        .i_data  ({wstrb, wdata}),
        .i_pop   (w_commit),
        .o_held  (w_w_held),
        .o_data  (w_w_bundle)
    );

    assign w_w_data = w_w_bundle[DATA_WIDTH-1:0];
    assign w_w_strb = w_w_bundle[STRB_W+DATA_WIDTH-1:DATA_WIDTH];

    // A held AW/W pair commits only once the response slot is free or being emptied this edge.
    assign w_commit = w_aw_held && w_w_held && !(r_bvalid && !bready);
    assign w_wr_idx = addr_to_idx(w_aw_addr);
    assign w_wr_ok  = addr_in_range(w_aw_addr) && !(ID_EN && (w_wr_idx == '0));
    assign w_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(r_regs[w_wr_idx]),
                                             MAX_DATA_WIDTH'(w_w_data),
                                             (MAX_DATA_WIDTH/8)'(w_w_strb)));

    // NOTE: the register bank is software-visible state with defined reset values, so it is reset here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_wr_ok) begin
            r_regs[w_wr_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
            r_bvalid <= 1'b0;
        end
    end

    assign w_ar_accept   = arvalid && r_arready;
    assign w_rvalid_next = w_ar_accept || (r_rvalid && !rready);
    assign w_rd_in_range = addr_in_range(araddr);
    assign w_rd_idx      = addr_to_idx(araddr);

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        w_rd_value = '0;
        if (w_rd_in_range) begin
            if (ID_EN && (w_rd_idx == '0)) begin
                w_rd_value = DATA_WIDTH'(ID_VALUE);
            end else begin
                w_rd_value = r_regs[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= !w_rvalid_next;
            r_rvalid  <= w_rvalid_next;
            if (w_ar_accept) begin
                r_rdata <= w_rd_value;
                r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave: vector table plus hand-written handshake sequences.
module tb_axi4_lite_regfile_slave;
    import axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

`ifdef AXI_SLV_ID_REG_EN
    localparam logic [31:0] REG0_INIT = 32'h4E4F_4301;
`else
    localparam logic [31:0] REG0_INIT = 32'h0;
`endif

    logic          clk;
    logic          reset;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_checks = 0;
    int n_errors = 0;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid_seen", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        check("rd_rvalid_seen", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    logic [1:0]  t_resp;
    logic [31:0] t_data;

    initial begin
        vecs[0]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0};
        vecs[3]  = '{1'b0, 32'h40, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[4]  = '{1'b1, 32'h0C, 32'h1122_3344, 4'hF, RESP_OKAY,   32'h0};
        vecs[5]  = '{1'b1, 32'h0C, 32'hAABB_CCDD, 4'h5, RESP_OKAY,   32'h0};
        vecs[6]  = '{1'b0, 32'h0C, 32'h0,         4'h0, RESP_OKAY,   32'h11BB_33DD};
        vecs[7]  = '{1'b1, 32'h0F, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   32'h0};
        vecs[8]  = '{1'b0, 32'h0E, 32'h0,         4'h0, RESP_OKAY,   32'h11BB_33DD};
        vecs[9]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'h0};
        vecs[10] = '{1'b0, 32'h3F, 32'h0,         4'h0, RESP_OKAY,   32'hCAFE_F00D};
        vecs[11] = '{1'b0, 32'h44, 32'h0,         4'h0, RESP_SLVERR, 32'h0};
        vecs[12] = '{1'b0, 32'h10, 32'h0,         4'h0, RESP_OKAY,   32'h0};
        vecs[13] = '{1'b0, 32'h00, 32'h0,         4'h0, RESP_OKAY,   REG0_INIT};

        reset = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        #3;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        #9 reset = 1'b1;
        tick();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready",  32'(wready),  32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // Write latency: AW+W same edge, bvalid after the following edge
        awaddr = 32'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("lat_bvalid_early", 32'(bvalid),  32'd0);
        check("lat_awready_held", 32'(awready), 32'd0);
        tick();
        check("lat_bvalid", 32'(bvalid), 32'd1);
        check("lat_bresp",  32'(bresp),  32'(RESP_OKAY));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("lat_bvalid_clr", 32'(bvalid), 32'd0);
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("lat_rvalid",  32'(rvalid),  32'd1);
        check("lat_rdata",   rdata,        32'hDEAD_BEEF);
        check("lat_rresp",   32'(rresp),   32'(RESP_OKAY));
        check("lat_arready", 32'(arready), 32'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("lat_rvalid_clr", 32'(rvalid), 32'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, t_resp);
                check($sformatf("vec%0d_bresp", i), 32'(t_resp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, t_data, t_resp);
                check($sformatf("vec%0d_rdata", i), t_data, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), 32'(t_resp), 32'(vecs[i].exp_resp));
            end
        end

        // W before AW: wready stays low while W is held
        axi_write(32'h04, 32'h1122_3344, 4'hF, t_resp);
        wdata = 32'hAAAA_5555; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_c1", 32'(wready), 32'd0);
        tick();
        check("wfirst_wready_c2", 32'(wready), 32'd0);
        tick();
        check("wfirst_wready_c3", 32'(wready), 32'd0);
        check("wfirst_bvalid_c3", 32'(bvalid), 32'd0);
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid_early", 32'(bvalid), 32'd0);
        tick();
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_bresp",  32'(bresp),  32'(RESP_OKAY));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(32'h04, t_data, t_resp);
        check("wfirst_rdata", t_data, 32'h1122_5555);

        // B back-pressure with a second write queued behind it
        awaddr = 32'h14; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("bp_bvalid1", 32'(bvalid), 32'd1);
        awaddr = 32'h18; wdata = 32'h2222_2222; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_hold_bvalid%0d", k), 32'(bvalid), 32'd1);
            check($sformatf("bp_hold_bresp%0d", k), 32'(bresp), 32'(RESP_OKAY));
            check($sformatf("bp_hold_awready%0d", k), 32'(awready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_bvalid2", 32'(bvalid), 32'd1);
        tick();
        check("bp_bvalid_done", 32'(bvalid), 32'd0);
        bready = 1'b0;
        axi_read(32'h14, t_data, t_resp);
        check("bp_rdata1", t_data, 32'h1111_1111);
        axi_read(32'h18, t_data, t_resp);
        check("bp_rdata2", t_data, 32'h2222_2222);

        // Read and write commit to the same register on one edge: old value returned
        axi_write(32'h20, 32'h1, 4'hF, t_resp);
        awaddr = 32'h20; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h20; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("same_edge_rvalid", 32'(rvalid), 32'd1);
        check("same_edge_rdata",  rdata,       32'h1);
        check("same_edge_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h20, t_data, t_resp);
        check("same_edge_after", t_data, 32'h2);

        // R back-pressure: rdata stable and arready low while rready is low
        axi_write(32'h1C, 32'h0BAD_CAFE, 4'hF, t_resp);
        araddr = 32'h1C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rbp_rvalid%0d", k), 32'(rvalid), 32'd1);
            check($sformatf("rbp_rdata%0d", k), rdata, 32'h0BAD_CAFE);
            check($sformatf("rbp_arready%0d", k), 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rbp_rvalid_clr", 32'(rvalid),  32'd0);
        check("rbp_arready_up", 32'(arready), 32'd1);

        // Register 0 behaviour
`ifdef AXI_SLV_ID_REG_EN
        axi_read(32'h00, t_data, t_resp);
        check("id_rdata", t_data, 32'h4E4F_4301);
        axi_write(32'h00, 32'h5, 4'hF, t_resp);
        check("id_wr_bresp", 32'(t_resp), 32'(RESP_SLVERR));
        axi_read(32'h00, t_data, t_resp);
        check("id_rdata_after_wr", t_data, 32'h4E4F_4301);
`else
        axi_write(32'h00, 32'h5, 4'hF, t_resp);
        check("reg0_wr_bresp", 32'(t_resp), 32'(RESP_OKAY));
        axi_read(32'h00, t_data, t_resp);
        check("reg0_rdata", t_data, 32'h5);
`endif

        // Reset with AW held and W missing
        awaddr = 32'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_awready_held", 32'(awready), 32'd0);
        check("mid_bvalid",       32'(bvalid),  32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_awready", 32'(awready), 32'd0);
        check("mid_rst_wready",  32'(wready),  32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        check("mid_rst_bvalid",  32'(bvalid),  32'd0);
        check("mid_rst_rvalid",  32'(rvalid),  32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        check("mid_post_awready", 32'(awready), 32'd1);
        axi_read(32'h08, t_data, t_resp);
        check("mid_reg2_cleared", t_data, 32'h0);
        axi_read(32'h1C, t_data, t_resp);
        check("mid_reg7_cleared", t_data, 32'h0);
        axi_read(32'h00, t_data, t_resp);
        check("mid_reg0_after_rst", t_data, REG0_INIT);
        wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("mid_stale_aw_dropped", 32'(bvalid), 32'd0);
        awaddr = 32'h24; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        check("mid_new_bvalid", 32'(bvalid), 32'd1);
        check("mid_new_bresp",  32'(bresp),  32'(RESP_OKAY));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(32'h24, t_data, t_resp);
        check("mid_new_rdata", t_data, 32'h5A5A_5A5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
